kernel_tap_seq: RTL and testbench

Parametrised kernel tap sequencer for the convolution datapath. Accepts one K×K neighbourhood window per handshake and streams its taps out one per cycle, in row-major order, under valid/ready flow control. A mode input selects which taps are emitted: the full window, the cross, the border, or the centre only. It generalises the fixed 3×3 position select: it adds arbitrary window size, subset modes, buffering and backpressure.

---
 rtl/kernel_pkg.sv | 29 ++
 rtl/kernel_next_tap.sv | 28 ++
 rtl/kernel_tap_seq.sv | 80 ++++++++
 tb/tb_kernel_tap_seq.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/kernel_pkg.sv
// kernel_pkg: tap-subset modes and window geometry helpers for the kernel tap sequencer
package kernel_pkg;
  typedef enum logic [1:0] {
    KMODE_FULL   = 2'b00,
    KMODE_CROSS  = 2'b01,
    KMODE_BORDER = 2'b10,
    KMODE_CENTRE = 2'b11
  } kmode_e;

  function automatic int centre_idx(input int k);
    return (k * k - 1) / 2;
  endfunction

  function automatic logic tap_enabled(input int idx, input kmode_e mode, input int k);
    int m;
    m = (k - 1) / 2;
    return mode == KMODE_FULL  ? 1'b1 :
           mode == KMODE_CROSS ? ((idx / k == m) || (idx % k == m)) :
           mode == KMODE_BORDER ? (idx != centre_idx(k)) :
                                  (idx == centre_idx(k));
  endfunction

  function automatic int tap_count(input kmode_e mode, input int k);
    int n;
    n = 0;
    for (int i = 0; i < k * k; i++) n += int'(tap_enabled(i, mode, k));
    return n;
  endfunction
endpackage

// File: rtl/kernel_next_tap.sv
// kernel_next_tap: finds the next enabled tap above cur_i (or the first one when start_i) and flags the final one
module kernel_next_tap
  import kernel_pkg::*;
#(
  parameter int K     = 3,
  parameter int IDX_W = $clog2(K * K)
) (
  input  logic             start_i,
  input  logic [IDX_W-1:0] cur_i,
  input  kmode_e           mode_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             last_o
);
  logic seen;
  // Descending scan: the lowest qualifying index wins, and it is last if no enabled tap lies above it
  always_comb begin
    idx_o  = '0;
    last_o = 1'b1;
    seen   = 1'b0;
    for (int i = K * K - 1; i >= 0; i--) begin
      if (tap_enabled(i, mode_i, K) && (start_i || i > int'(cur_i))) begin
        idx_o  = IDX_W'(i);
        last_o = ~seen;
      end
      if (tap_enabled(i, mode_i, K)) seen = 1'b1;
    end
  end
endmodule

// File: rtl/kernel_tap_seq.sv
// kernel_tap_seq: holds one KxK window and streams its mode-selected taps one per cycle under valid/ready
module kernel_tap_seq
  import kernel_pkg::*;
#(
  parameter int DATA_W = 3,
  parameter int K      = 3,
  parameter int IDX_W  = $clog2(K * K)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  win_valid,
  output logic                  win_ready,
  input  logic [K*K*DATA_W-1:0] win_data,
  input  logic [1:0]            win_mode,
  output logic                  tap_valid,
  input  logic                  tap_ready,
  output logic [DATA_W-1:0]     tap_data,
  output logic [IDX_W-1:0]      tap_idx,
  output logic                  tap_last,
  output logic                  busy
);
  typedef enum logic {IDLE, STREAM} state_e;

  state_e                state_q, state_d;
  logic [K*K*DATA_W-1:0] win_q, win_d, src;
  kmode_e                mode_q, mode_d, nt_mode;
  logic [DATA_W-1:0]     data_q, data_d;
  logic [IDX_W-1:0]      idx_q, idx_d, nt_idx;
  logic                  last_q, last_d, nt_last;
  logic                  accept, advance, done, load;

  assign tap_valid = state_q == STREAM;
  assign busy      = tap_valid;
  assign tap_data  = data_q;
  assign tap_idx   = idx_q;
  assign tap_last  = last_q;
  assign done      = tap_valid & tap_ready & last_q;
  assign win_ready = (state_q == IDLE) | done;

  kernel_next_tap #(.K(K), .IDX_W(IDX_W)) u_next (
    .start_i(accept),
    .cur_i  (idx_q),
    .mode_i (nt_mode),
    .idx_o  (nt_idx),
    .last_o (nt_last)
  );

  // A newly accepted window is searched straight from the input so its first tap is ready next cycle
  always_comb begin
    accept  = win_valid & win_ready;
    advance = tap_valid & tap_ready & ~last_q;
    load    = accept | advance;
    nt_mode = accept ? kmode_e'(win_mode) : mode_q;
    src     = accept ? win_data : win_q;
    state_d = accept ? STREAM : done ? IDLE : state_q;
    win_d   = accept ? win_data : win_q;
    mode_d  = nt_mode;
    idx_d   = load ? nt_idx : idx_q;
    last_d  = load ? nt_last : last_q;
    data_d  = load ? src[int'(nt_idx)*DATA_W +: DATA_W] : data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      win_q   <= '0;
      mode_q  <= KMODE_FULL;
      data_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end
endmodule

// File: tb/tb_kernel_tap_seq.sv
// tb_kernel_tap_seq: scoreboard bench for K=3 and K=5 sequencers against an expected-tap-list model
module tb_kernel_tap_seq;
  typedef struct {int idx; int data; bit last;} tap_t;
  typedef tap_t tap_q_t[$];

  logic clk = 0, rst_n = 1;
  always #5 clk = ~clk;

  logic        w3_valid = 0, w3_ready, t3_valid, t3_ready = 1, t3_last, b3;
  logic [35:0] w3_data = '0;
  logic [1:0]  w3_mode = '0;
  logic [3:0]  t3_data, t3_idx;
  logic        w5_valid = 0, w5_ready, t5_valid, t5_ready = 1, t5_last, b5;
  logic [99:0] w5_data = '0;
  logic [1:0]  w5_mode = '0;
  logic [3:0]  t5_data;
  logic [4:0]  t5_idx;

  int     n_chk = 0, n_pass = 0;
  bit     rnd = 0;
  tap_q_t qs[2];

  kernel_tap_seq #(.DATA_W(4), .K(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .win_valid(w3_valid), .win_ready(w3_ready), .win_data(w3_data),
    .win_mode(w3_mode), .tap_valid(t3_valid), .tap_ready(t3_ready), .tap_data(t3_data),
    .tap_idx(t3_idx), .tap_last(t3_last), .busy(b3)
  );

  kernel_tap_seq #(.DATA_W(4), .K(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .win_valid(w5_valid), .win_ready(w5_ready), .win_data(w5_data),
    .win_mode(w5_mode), .tap_valid(t5_valid), .tap_ready(t5_ready), .tap_data(t5_data),
    .tap_idx(t5_idx), .tap_last(t5_last), .busy(b5)
  );

  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Expected emission list of one window, built directly from the row/column subset rules
  function automatic tap_q_t expand(logic [99:0] w, int mode, int k);
    tap_q_t q;
    int m, r, c;
    bit en;
    m = k / 2;
    for (int i = 0; i < k * k; i++) begin
      r  = i / k;
      c  = i % k;
      en = mode == 0 || (mode == 1 && (r == m || c == m)) ||
           (mode == 2 && i != k * k / 2) || (mode == 3 && i == k * k / 2);
      if (en) q.push_back('{i, int'(w[i*4 +: 4]), 1'b0});
    end
    q[q.size()-1].last = 1;
    return q;
  endfunction

  task automatic mon(int d, logic v, logic r, int idx, int data, logic last, logic wr, logic bsy,
                     logic wv, logic [99:0] w, int mode, int k);
    tap_q_t t;
    string  p;
    p = $sformatf("k%0d", k);
    chk({p, " tap_valid"}, v, int'(qs[d].size() != 0));
    chk({p, " busy"}, bsy, int'(qs[d].size() != 0));
    chk({p, " win_ready"}, wr, int'(qs[d].size() == 0 || (qs[d].size() == 1 && r)));
    if (v && qs[d].size() != 0) begin
      chk({p, " tap_idx"}, idx, qs[d][0].idx);
      chk({p, " tap_data"}, data, qs[d][0].data);
      chk({p, " tap_last"}, last, int'(qs[d][0].last));
      if (r) void'(qs[d].pop_front());
    end
    if (wv && wr) begin
      t = expand(w, mode, k);
      foreach (t[j]) qs[d].push_back(t[j]);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) qs[0].delete();
    else mon(0, t3_valid, t3_ready, int'(t3_idx), int'(t3_data), t3_last, w3_ready, b3,
             w3_valid, {64'd0, w3_data}, int'(w3_mode), 3);
  end

  always @(negedge clk) begin
    if (!rst_n) qs[1].delete();
    else mon(1, t5_valid, t5_ready, int'(t5_idx), int'(t5_data), t5_last, w5_ready, b5,
             w5_valid, w5_data, int'(w5_mode), 5);
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd) begin
      t3_ready = $urandom_range(0, 3) != 0;
      t5_ready = $urandom_range(0, 3) != 0;
    end
    #1;
  endtask

  task automatic send(int d, logic [99:0] w, int mode);
    bit ok;
    ok = 0;
    if (d == 0) begin w3_valid = 1; w3_data = w[35:0]; w3_mode = 2'(mode); end
    else begin w5_valid = 1; w5_data = w; w5_mode = 2'(mode); end
    for (int n = 0; n < 300 && !ok; n++) begin
      ok = d == 0 ? w3_ready : w5_ready;
      step();
    end
    if (!ok) chk("accept timeout", 0, 1);
    w3_valid = 0;
    w5_valid = 0;
  endtask

  task automatic wait_idx(int target);
    bit hit;
    hit = 0;
    for (int n = 0; n < 100 && !hit; n++) begin
      hit = t3_valid && int'(t3_idx) == target;
      if (!hit) step();
    end
    if (!hit) chk("wait idx timeout", 0, 1);
  endtask

  task automatic drain();
    for (int n = 0; n < 1000 && (qs[0].size() != 0 || qs[1].size() != 0); n++) step();
    chk("drain", qs[0].size() + qs[1].size(), 0);
  endtask

  initial begin
    logic [99:0]  id3, rev3, id5, w;
    logic [127:0] r128;
    id3  = '0;
    rev3 = '0;
    id5  = '0;
    for (int i = 0; i < 9; i++) begin id3[i*4 +: 4] = 4'(i); rev3[i*4 +: 4] = 4'(15 - i); end
    for (int i = 0; i < 25; i++) id5[i*4 +: 4] = 4'(i);
    #1 rst_n = 0;
    #11;
    chk("rst tap_valid", t3_valid, 0);
    chk("rst win_ready", w3_ready, 1);
    chk("rst tap_idx", t3_idx, 0);
    chk("rst tap_data", t3_data, 0);
    chk("rst tap_last", t3_last, 0);
    chk("rst busy", b3, 0);
    chk("rst k5 tap_valid", t5_valid, 0);
    @(posedge clk);
    #1 rst_n = 1;
    step();
    for (int m = 0; m < 4; m++) begin
      send(0, id3, m);
      drain();
    end
    send(0, id3, 0);
    wait_idx(3);
    t3_ready = 0;
    repeat (3) begin
      w3_data = 36'($urandom());
      step();
    end
    t3_ready = 1;
    drain();
    send(0, id3, 0);
    send(0, rev3, 0);
    drain();
    send(1, id5, 1);
    drain();
    send(0, id3, 0);
    wait_idx(5);
    rst_n = 0;
    #1;
    chk("midrst tap_valid", t3_valid, 0);
    chk("midrst tap_idx", t3_idx, 0);
    chk("midrst win_ready", w3_ready, 1);
    step();
    rst_n = 1;
    repeat (4) step();
    rnd = 1;
    for (int n = 0; n < 40; n++) begin
      r128 = {$urandom(), $urandom(), $urandom(), $urandom()};
      w    = r128[99:0];
      send(int'($urandom_range(0, 1)), w, int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) step();
    end
    drain();
    rnd = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
